// File: rtl/bestmove_tx_formatter.sv
// Serialises one chosen move into the UCI line "bestmove <move>\n", one byte per valid/ready transfer.
// First byte appears the cycle after acceptance; a stalled byte is held stable, and one extra move can wait in a pending slot.
module bestmove_tx_formatter #(
  parameter bit EMIT_PREFIX = 1'b1,
  parameter bit CRLF        = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [5:0] move_from_in,
  input  logic [5:0] move_to_in,
  input  logic [2:0] move_promo_in,
  input  logic       move_valid_in,
  output logic       ready_out,
  output logic [7:0] char_out,
  output logic       char_out_valid,
  input  logic       char_out_ready,
  output logic       busy_out,
  output logic       overflow_out
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_FROM_FILE,
    ST_FROM_RANK,
    ST_TO_FILE,
    ST_TO_RANK,
    ST_PROMO,
    ST_CR,
    ST_LF
  } state_t;

  localparam state_t FIRST_ST = EMIT_PREFIX ? ST_PREFIX : ST_FROM_FILE;
  localparam state_t END_ST   = CRLF ? ST_CR : ST_LF;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [5:0] act_from_q, act_from_d;
  logic [5:0] act_to_q, act_to_d;
  logic [2:0] act_promo_q, act_promo_d;
  logic       pend_vld_q, pend_vld_d;
  logic [5:0] pend_from_q, pend_from_d;
  logic [5:0] pend_to_q, pend_to_d;
  logic [2:0] pend_promo_q, pend_promo_d;
  logic       ovf_q, ovf_d;

  logic xfer;
  logic line_done;
  logic null_mv;
  logic has_promo;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_IDLE;
      idx_q        <= 4'd0;
      act_from_q   <= 6'd0;
      act_to_q     <= 6'd0;
      act_promo_q  <= 3'd0;
      pend_vld_q   <= 1'b0;
      pend_from_q  <= 6'd0;
      pend_to_q    <= 6'd0;
      pend_promo_q <= 3'd0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      act_from_q   <= act_from_d;
      act_to_q     <= act_to_d;
      act_promo_q  <= act_promo_d;
      pend_vld_q   <= pend_vld_d;
      pend_from_q  <= pend_from_d;
      pend_to_q    <= pend_to_d;
      pend_promo_q <= pend_promo_d;
      ovf_q        <= ovf_d;
    end
  end

  assign xfer      = (state_q != ST_IDLE) && char_out_ready;
  assign line_done = xfer && (state_q == ST_LF);
  // A null move prints "0000" and never carries a promotion letter.
  assign null_mv   = (act_from_q == act_to_q);
  assign has_promo = !null_mv && (act_promo_q != 3'd0) && (act_promo_q <= 3'd4);

  assign char_out_valid = (state_q != ST_IDLE);
  assign busy_out       = (state_q != ST_IDLE);
  assign ready_out      = !pend_vld_q;
  assign overflow_out   = ovf_q;

  always_comb begin
    char_out = 8'h00;
    case (state_q)
      ST_PREFIX: begin
        case (idx_q)
          4'd0:    char_out = 8'h62;
          4'd1:    char_out = 8'h65;
          4'd2:    char_out = 8'h73;
          4'd3:    char_out = 8'h74;
          4'd4:    char_out = 8'h6d;
          4'd5:    char_out = 8'h6f;
          4'd6:    char_out = 8'h76;
          4'd7:    char_out = 8'h65;
          default: char_out = 8'h20;
        endcase
      end
      ST_FROM_FILE: char_out = null_mv ? 8'h30 : 8'h61 + {5'd0, act_from_q[2:0]};
      ST_FROM_RANK: char_out = null_mv ? 8'h30 : 8'h31 + {5'd0, act_from_q[5:3]};
      ST_TO_FILE:   char_out = null_mv ? 8'h30 : 8'h61 + {5'd0, act_to_q[2:0]};
      ST_TO_RANK:   char_out = null_mv ? 8'h30 : 8'h31 + {5'd0, act_to_q[5:3]};
      ST_PROMO: begin
        case (act_promo_q)
          3'd1:    char_out = 8'h6e;
          3'd2:    char_out = 8'h62;
          3'd3:    char_out = 8'h72;
          3'd4:    char_out = 8'h71;
          default: char_out = 8'h00;
        endcase
      end
      ST_CR:   char_out = 8'h0d;
      ST_LF:   char_out = 8'h0a;
      default: char_out = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    act_from_d   = act_from_q;
    act_to_d     = act_to_q;
    act_promo_d  = act_promo_q;
    pend_vld_d   = pend_vld_q;
    pend_from_d  = pend_from_q;
    pend_to_d    = pend_to_q;
    pend_promo_d = pend_promo_q;
    ovf_d        = 1'b0;

    if (xfer) begin
      case (state_q)
        ST_PREFIX: begin
          if (idx_q == 4'd8) begin
            state_d = ST_FROM_FILE;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        ST_FROM_FILE: state_d = ST_FROM_RANK;
        ST_FROM_RANK: state_d = ST_TO_FILE;
        ST_TO_FILE:   state_d = ST_TO_RANK;
        ST_TO_RANK:   state_d = has_promo ? ST_PROMO : END_ST;
        ST_PROMO:     state_d = END_ST;
        ST_CR:        state_d = ST_LF;
        ST_LF: begin
          if (pend_vld_q) begin
            act_from_d  = pend_from_q;
            act_to_d    = pend_to_q;
            act_promo_d = pend_promo_q;
            pend_vld_d  = 1'b0;
            state_d     = FIRST_ST;
            idx_d       = 4'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A strobe landing on the final LF transfer with nothing pending goes straight
    // to active, which is the same as entering pending and being promoted at once.
    if (move_valid_in) begin
      if (pend_vld_q) begin
        ovf_d = 1'b1;
      end else if ((state_q == ST_IDLE) || line_done) begin
        act_from_d  = move_from_in;
        act_to_d    = move_to_in;
        act_promo_d = move_promo_in;
        state_d     = FIRST_ST;
        idx_d       = 4'd0;
      end else begin
        pend_from_d  = move_from_in;
        pend_to_d    = move_to_in;
        pend_promo_d = move_promo_in;
        pend_vld_d   = 1'b1;
      end
    end
  end

endmodule
